vga_sync_ctrl: RTL and testbench

Timing controller for the VGA output path. It sequences the horizontal and vertical scan through explicit porch/sync state machines and drives hsync, vsync, blanking and pixel coordinates. It also runs a per-line prefetch handshake with the line-buffer filler and flags underruns. It sits between the 50 MHz system clock and the pixel generator, and uses a 2:1 pixel enable: 800 pixels per line equals 1600 Clk cycles per line.

---
 rtl/vga_sync_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_vga_sync_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_ctrl.sv
// vga_sync_ctrl: VGA scan timing with porch/sync state machines, a 2:1 pixel
// enable, and a per-line prefetch handshake that flags late line-buffer fills.
module vga_sync_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       line_ack,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_tick,
    output logic       line_end,
    output logic       frame_start,
    output logic       line_req,
    output logic [9:0] line_y,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_VISIBLE  = 10'(V_ACTIVE);

    typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SY = 2'd2, H_BP = 2'd3} hstate_t;
    typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SY = 2'd2, V_BP = 2'd3} vstate_t;

    logic       pix_tick_q, pix_tick_d;
    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    hstate_t    hstate_q, hstate_d;
    vstate_t    vstate_q, vstate_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       line_end_q, line_end_d;
    logic       frame_start_q, frame_start_d;
    logic       line_req_q, line_req_d;
    logic [9:0] line_y_q, line_y_d;
    logic       underrun_q, underrun_d;

    logic       h_wrap_s;
    logic       bp_entry_s;
    logic [9:0] next_line_s;

    // Wrap of the horizontal counter and the line that follows the current one.
    always_comb begin
        h_wrap_s    = pix_tick_q && (hpos_q == H_LAST);
        next_line_s = (vpos_q == V_LAST) ? 10'd0 : (vpos_q + 10'd1);
    end

    // Pixel enable toggles every clock; scan counters advance on enabled clocks.
    always_comb begin
        pix_tick_d = ~pix_tick_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        if (h_wrap_s) begin
            hpos_d = 10'd0;
            vpos_d = next_line_s;
        end else if (pix_tick_q) begin
            hpos_d = hpos_q + 10'd1;
        end else begin
            hpos_d = hpos_q;
        end
    end

    // Horizontal state machine follows the next horizontal position.
    always_comb begin
        hstate_d = hstate_q;
        if (pix_tick_q) begin
            case (hstate_q)
                H_ACT:   hstate_d = (hpos_d == H_FP_START) ? H_FP  : H_ACT;
                H_FP:    hstate_d = (hpos_d == H_SY_START) ? H_SY  : H_FP;
                H_SY:    hstate_d = (hpos_d == H_BP_START) ? H_BP  : H_SY;
                H_BP:    hstate_d = (hpos_d == 10'd0)      ? H_ACT : H_BP;
                default: hstate_d = H_ACT;
            endcase
        end else begin
            hstate_d = hstate_q;
        end
    end

    // Vertical state machine only moves on the end-of-line wrap.
    always_comb begin
        vstate_d = vstate_q;
        if (h_wrap_s) begin
            case (vstate_q)
                V_ACT:   vstate_d = (vpos_d == V_FP_START) ? V_FP  : V_ACT;
                V_FP:    vstate_d = (vpos_d == V_SY_START) ? V_SY  : V_FP;
                V_SY:    vstate_d = (vpos_d == V_BP_START) ? V_BP  : V_SY;
                V_BP:    vstate_d = (vpos_d == 10'd0)      ? V_ACT : V_BP;
                default: vstate_d = V_ACT;
            endcase
        end else begin
            vstate_d = vstate_q;
        end
    end

    // Sync/blank outputs track the next states so they align with pixel_x/pixel_y.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        line_end_d    = h_wrap_s;
        frame_start_d = h_wrap_s && (vpos_q == V_LAST);
        if (pix_tick_q) begin
            hsync_d    = (hstate_d != H_SY);
            vsync_d    = (vstate_d != V_SY);
            video_on_d = (hstate_d == H_ACT) && (vstate_d == V_ACT);
        end else begin
            hsync_d    = hsync_q;
            vsync_d    = vsync_q;
            video_on_d = video_on_q;
        end
    end

    // Prefetch handshake: request the next visible line at back-porch entry;
    // an ack always wins, otherwise the line start is a hard deadline.
    always_comb begin
        bp_entry_s = pix_tick_q && (hstate_q == H_SY) && (hstate_d == H_BP);
        line_req_d = line_req_q;
        line_y_d   = line_y_q;
        underrun_d = underrun_q;
        if (line_req_q) begin
            if (line_ack) begin
                line_req_d = 1'b0;
            end else if (h_wrap_s) begin
                line_req_d = 1'b0;
                underrun_d = 1'b1;
            end else begin
                line_req_d = 1'b1;
            end
        end else if (bp_entry_s && (next_line_s < V_VISIBLE)) begin
            line_req_d = 1'b1;
            line_y_d   = next_line_s;
        end else begin
            line_req_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pix_tick_q    <= 1'b0;
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            hstate_q      <= H_ACT;
            vstate_q      <= V_ACT;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            line_req_q    <= 1'b0;
            line_y_q      <= 10'd0;
            underrun_q    <= 1'b0;
        end else begin
            pix_tick_q    <= pix_tick_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hstate_q      <= hstate_d;
            vstate_q      <= vstate_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
            line_req_q    <= line_req_d;
            line_y_q      <= line_y_d;
            underrun_q    <= underrun_d;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign pixel_x     = hpos_q;
    assign pixel_y     = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;
    assign line_req    = line_req_q;
    assign line_y      = line_y_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: default horizontal timing, shortened vertical
// timing so several frames fit in a short run. A position model derived from
// the clock count since reset predicts every output on every cycle.
module tb_vga_sync_ctrl;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 7, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       line_ack = 1'b1;
    logic       hsync, vsync, video_on, pix_tick, line_end, frame_start, line_req, underrun;
    logic [9:0] pixel_x, pixel_y, line_y;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // model state: clock edges since reset, plus handshake expectations
    int   k = 0;
    bit   m_req = 1'b0;
    bit   m_und = 1'b0;
    int   m_ly = 0;

    vga_sync_ctrl #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .line_ack(line_ack),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_tick(pix_tick),
        .line_end(line_end), .frame_start(frame_start),
        .line_req(line_req), .line_y(line_y), .underrun(underrun)
    );

    always #10 Clk = ~Clk;

    function automatic int pos_x(input int kk);
        return (kk / 2) % HT;
    endfunction

    function automatic int pos_y(input int kk);
        return ((kk / 2) / HT) % VT;
    endfunction

    function automatic int next_line(input int y);
        return (y == VT - 1) ? 0 : y + 1;
    endfunction

    // Handshake model: acts on the position in force just before each edge.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            k     <= 0;
            m_req <= 1'b0;
            m_und <= 1'b0;
            m_ly  <= 0;
        end else begin
            k <= k + 1;
            if (m_req) begin
                if (line_ack) begin
                    m_req <= 1'b0;
                end else if ((k % 2 == 1) && (pos_x(k) == HT - 1)) begin
                    m_req <= 1'b0;
                    m_und <= 1'b1;
                end
            end else if ((k % 2 == 1) && (pos_x(k) == HA + HF + HS - 1)
                         && (next_line(pos_y(k)) < VA)) begin
                m_req <= 1'b1;
                m_ly  <= next_line(pos_y(k));
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        int x, y;
        logic [37:0] got, exp;
        if (cmp_en) begin
            x = pos_x(k);
            y = pos_y(k);
            exp = {1'(k % 2),
                   1'(!(x >= HA + HF && x < HA + HF + HS)),
                   1'(!(y >= VA + VF && y < VA + VF + VS)),
                   1'((k >= 2) && (x < HA) && (y < VA)),
                   1'((k >= 2) && (k % 2 == 0) && (x == 0)),
                   1'((k >= 2) && (k % 2 == 0) && (x == 0) && (y == 0)),
                   m_req, m_und, 10'(x), 10'(y), 10'(m_ly)};
            got = {pix_tick, hsync, vsync, video_on, line_end, frame_start,
                   line_req, underrun, pixel_x, pixel_y, line_y};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL scan t=%0t got=%h required=%h (tick,hs,vs,von,le,fs,req,und,x,y,ly)",
                         $time, got, exp);
                if (errors > 200) begin
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0: return hsync;
            1: return vsync;
            2: return line_end;
            3: return frame_start;
            4: return line_req;
            5: return underrun;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (sampling at falling edges) until the selected output equals val.
    task automatic wait_for(input int sel, input logic val, input int limit);
        int n = 0;
        while (sig_sel(sel) !== val && n < limit) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_sel%0d got timeout required value %0d within %0d cycles", sel, val, limit);
        end
    endtask

    // Cycles between two successive rising occurrences of a pulse output.
    task automatic pulse_period(input int sel, input int limit, output int cycles);
        time t0;
        wait_for(sel, 1'b1, limit);
        t0 = $time;
        @(negedge Clk);
        wait_for(sel, 1'b1, limit);
        cycles = int'(($time - t0) / 20);
    endtask

    initial begin
        int per, d, oy;
        time t0;

        // reset values
        @(negedge Clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_pixel_x", pixel_x, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_video_on", video_on, 0);
        check("rst_pix_tick", pix_tick, 0);
        check("rst_line_req", line_req, 0);
        #3 Reset = 1'b0;

        // horizontal timing, ack tied high
        @(negedge Clk);
        check("first_tick", pix_tick, 1);
        @(negedge Clk);
        check("first_x", pixel_x, 1);
        wait_for(0, 1'b0, 2000);
        check("hsync_fall_x", pixel_x, 656);
        t0 = $time;
        wait_for(0, 1'b1, 400);
        check("hsync_rise_x", pixel_x, 752);
        check("hsync_width", int'(($time - t0) / 20), 192);
        pulse_period(2, 2000, per);
        check("line_period", per, 1600);

        // vertical timing and frame period
        wait_for(1, 1'b0, 20000);
        check("vsync_fall_y", pixel_y, VA + VF);
        t0 = $time;
        wait_for(1, 1'b1, 5000);
        check("vsync_width", int'(($time - t0) / 20), 3200);
        pulse_period(3, 40000, per);
        check("frame_period", per, HT * VT * 2);
        check("underrun_ack_high", underrun, 0);

        // randomized ack latency on each request of one frame
        line_ack = 1'b0;
        for (int r = 0; r < 7; r++) begin
            wait_for(4, 1'b1, 8000);
            oy = int'(pixel_y);
            if (oy == 5) check("req_y5_line", line_y, 6);
            if (oy == VT - 1) check("req_last_line", line_y, 0);
            d = (oy == 5) ? 10 : int'($urandom_range(0, 40));
            repeat (d) @(negedge Clk);
            line_ack = 1'b1;
            @(negedge Clk);
            line_ack = 1'b0;
            check("req_cleared_by_ack", line_req, 0);
        end

        // ack on exactly the deadline edge
        wait_for(4, 1'b1, 4000);
        for (int n = 0; n < 300 && !(pixel_x == 10'd799 && pix_tick); n++) @(negedge Clk);
        line_ack = 1'b1;
        @(negedge Clk);
        line_ack = 1'b0;
        check("deadline_ack_x", pixel_x, 0);
        check("deadline_ack_req", line_req, 0);
        check("deadline_ack_und", underrun, 0);

        // no ack: underrun sets and survives a frame boundary
        wait_for(5, 1'b1, 4000);
        check("underrun_set_x", pixel_x, 0);
        wait_for(3, 1'b1, 20000);
        repeat (5) @(negedge Clk);
        check("underrun_sticky", underrun, 1);

        // asynchronous reset late in a line with a request pending
        wait_for(4, 1'b1, 4000);
        for (int n = 0; n < 200 && pixel_x < 10'd780; n++) @(negedge Clk);
        check("pre_reset_req", line_req, 1);
        #3 Reset = 1'b1;
        #1;
        check("async_x", pixel_x, 0);
        check("async_y", pixel_y, 0);
        check("async_req", line_req, 0);
        check("async_und", underrun, 0);
        check("async_tick", pix_tick, 0);
        repeat (3) @(negedge Clk);
        #3 Reset = 1'b0;
        repeat (1550) @(negedge Clk);
        check("restart_und", underrun, 0);
        check("restart_req", line_req, 1);
        check("restart_line_y", line_y, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
